// File: rtl/sorted_drain_if.sv
// rtl/sorted_drain_if.sv - sorter pop port plus downstream valid/ready stream for sorted_drain.
interface sorted_drain_if #(parameter int W = 16) ();
  logic         src_pop;
  logic [W-1:0] src_dout;
  logic         src_empty;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  modport master (
    output src_pop,
    input  src_dout,
    input  src_empty,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  src_pop,
    output src_dout,
    output src_empty,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/sorted_drain.sv
// rtl/sorted_drain.sv - drains insertion_sort one element at a time onto a valid/ready stream.
// Define SORTED_DRAIN_DEDUP_EN to drop elements equal to the previously captured value.
module sorted_drain #(
  parameter int W       = 16,
  parameter int POP_LAT = 2,
  parameter int GAP     = 2,
  parameter int CW      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic                abort,
  sorted_drain_if.master      bus,
  output logic                done,
  output logic                busy,
  output logic [CW-1:0]       count,
  output logic                order_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_POP, S_WAIT, S_EMIT, S_GAP, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    lat_cnt, lat_nx;
  logic [3:0]    gap_cnt, gap_nx;
  logic [W-1:0]  hold, hold_nx;
  logic [W-1:0]  prev, prev_nx;
  logic          have_prev, have_prev_nx;
  logic [CW-1:0] count_nx;
  logic          order_err_nx;
  logic          done_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      gap_cnt   <= '0;
      hold      <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      count     <= '0;
      order_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      lat_cnt   <= lat_nx;
      gap_cnt   <= gap_nx;
      hold      <= hold_nx;
      prev      <= prev_nx;
      have_prev <= have_prev_nx;
      count     <= count_nx;
      order_err <= order_err_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    lat_nx       = lat_cnt;
    gap_nx       = gap_cnt;
    hold_nx      = hold;
    prev_nx      = prev;
    have_prev_nx = have_prev;
    count_nx     = count;
    order_err_nx = order_err;
    done_nx      = 1'b0;

    // Abort overrides the enable stall so a frozen block can still be pulled back to IDLE.
    if (abort) begin
      state_nx = S_IDLE;
    end else if (!enable) begin
      done_nx = done;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count_nx     = '0;
            order_err_nx = 1'b0;
            have_prev_nx = 1'b0;
            state_nx     = S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.src_empty) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_POP;
          end
        end
        S_POP: begin
          lat_nx   = 4'(POP_LAT);
          state_nx = S_WAIT;
        end
        S_WAIT: begin
          lat_nx = lat_cnt - 4'd1;
          if (lat_nx == 4'd0) begin
            prev_nx      = bus.src_dout;
            have_prev_nx = 1'b1;
            if (have_prev && (bus.src_dout < prev)) begin
              order_err_nx = 1'b1;
            end
`ifdef SORTED_DRAIN_DEDUP_EN
            if (have_prev && (bus.src_dout == prev)) begin
              gap_nx   = 4'(GAP);
              state_nx = S_GAP;
            end else begin
              hold_nx  = bus.src_dout;
              state_nx = S_EMIT;
            end
`else
            hold_nx  = bus.src_dout;
            state_nx = S_EMIT;
`endif
          end
        end
        S_EMIT: begin
          if (bus.m_ready) begin
            if (count != '1) begin
              count_nx = count + CW'(1);
            end
            gap_nx   = 4'(GAP);
            state_nx = S_GAP;
          end
        end
        S_GAP: begin
          gap_nx = gap_cnt - 4'd1;
          if (gap_nx == 4'd0) begin
            state_nx = S_CHECK;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign bus.src_pop = (state == S_POP) && enable;
  assign bus.m_valid = (state == S_EMIT);
  assign bus.m_data  = hold;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sorted_drain.sv
// tb/tb_sorted_drain.sv - randomized self-checking bench for sorted_drain against a queue-based reference.
module tb_sorted_drain;
  localparam int W       = 16;
  localparam int POP_LAT = 2;
  localparam int GAP     = 2;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          done, busy, order_err;
  logic [CW-1:0] count;

  sorted_drain_if #(.W(W)) bus ();

  sorted_drain #(.W(W), .POP_LAT(POP_LAT), .GAP(GAP), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .done      (done),
    .busy      (busy),
    .count     (count),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sorter model: data appears only in the cycle POP_LAT after the pop, garbage otherwise.
  logic [W-1:0] elems[$];
  int           gen = 0;
  int           seen_gen = 0;
  int           rd = 0;
  int           pend = 0;
  logic [W-1:0] pval;

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen;
      rd       = 0;
      pend     = 0;
    end
    if (pend > 0) begin
      pend--;
      bus.src_dout = (pend == 0) ? pval : W'($urandom);
    end else begin
      bus.src_dout = W'($urandom);
    end
    if (bus.src_pop && rd < elems.size()) begin
      pval = elems[rd];
      rd++;
      pend = POP_LAT;
    end
    bus.src_empty = (rd >= elems.size());
  end

  // Output monitor
  logic [W-1:0] got[$];
  logic         got_oe[$];
  int           pop_cyc[$];
  int           vr_cyc[$];
  int           dones = 0;
  int           done_cyc = -1;
  int           last_pop = -1000;
  int           spacing_viol = 0;
  int           hold_viol = 0;
  int           popdis_viol = 0;
  logic         prev_valid = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.src_pop) begin
        if (!enable) popdis_viol++;
        if (cyc - last_pop - 1 < POP_LAT + 1 + GAP) spacing_viol++;
        last_pop = cyc;
        pop_cyc.push_back(cyc);
      end
      if (stall_prev && (!bus.m_valid || bus.m_data !== data_prev)) hold_viol++;
      if (bus.m_valid && !prev_valid) vr_cyc.push_back(cyc);
      if (bus.m_valid && bus.m_ready && enable) begin
        got.push_back(bus.m_data);
        got_oe.push_back(order_err);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      stall_prev = bus.m_valid && !(bus.m_ready && enable) && !abort;
      prev_valid = bus.m_valid;
      data_prev  = bus.m_data;
    end
  end

  // Reference model: what the drain should emit and whether the captured stream descends anywhere.
  logic [W-1:0] stim[$];
  logic [W-1:0] exp_q[$];
  logic         exp_oe;
  int           exp_cnt;

  task automatic ref_model();
    exp_q.delete();
    exp_oe = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      if (i > 0 && stim[i] < stim[i-1]) exp_oe = 1'b1;
`ifdef SORTED_DRAIN_DEDUP_EN
      if (i > 0 && stim[i] == stim[i-1]) continue;
`endif
      exp_q.push_back(stim[i]);
    end
    exp_cnt = (exp_q.size() > 255) ? 255 : exp_q.size();
  endtask

  task automatic drain(input int bp, input bit en_stall, input bit timing);
    int base, p0, v0, d0, t0, n;
    ref_model();
    n    = stim.size();
    base = got.size();
    p0   = pop_cyc.size();
    v0   = vr_cyc.size();
    d0   = dones;
    elems = stim;
    gen++;
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 30000 && dones == d0; k++) begin
      bus.m_ready = ($urandom_range(99) >= bp);
      enable      = !(en_stall && bus.m_valid && ($urandom_range(3) == 0));
      tick(1);
    end
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    tick(2);
    check("done_pulses", dones - d0, 1);
    check("n_out", got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      check("data", 32'(got[base+i]), 32'(exp_q[i]));
    check("count", 32'(count), exp_cnt);
    check("order_err", 32'(order_err), 32'(exp_oe));
    check("pops", pop_cyc.size() - p0, n);
    if (timing) begin
      check("done_cycle", done_cyc, t0 + 2 + n * (POP_LAT + 3 + GAP));
      if (n > 0 && pop_cyc.size() > p0 && vr_cyc.size() > v0) begin
        check("pop_cycle", pop_cyc[p0], t0 + 2);
        check("valid_cycle", vr_cyc[v0], t0 + 3 + POP_LAT);
      end
    end
    check("pop_spacing", spacing_viol, 0);
    check("data_hold", hold_viol, 0);
    check("pop_when_disabled", popdis_viol, 0);
  endtask

  initial begin
    int b, p0, d0;
    logic [W-1:0] v;
    bus.m_ready = 1'b1;
    tick(3);
    check("rst_src_pop", 32'(bus.src_pop), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data", 32'(bus.m_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    check("rst_order_err", 32'(order_err), 0);
    rst = 1'b0;
    tick(2);

    stim = '{16'd3, 16'd7, 16'd9};
    drain(0, 1'b0, 1'b1);

    stim.delete();
    drain(0, 1'b0, 1'b1);

    stim = '{16'd5, 16'd5, 16'd5, 16'd8};
    drain(0, 1'b0, 1'b0);

    stim = '{16'd10, 16'd4, 16'd12};
    b = got.size();
    drain(0, 1'b0, 1'b0);
    if (got.size() >= b + 2) begin
      check("oe_before_descent", 32'(got_oe[b]), 0);
      check("oe_after_descent", 32'(got_oe[b+1]), 1);
    end

    stim.delete();
    drain(0, 1'b0, 1'b0);

    stim.delete();
    for (int i = 0; i < 200; i++) stim.push_back(W'($urandom_range(1000)));
    stim.sort();
    drain(40, 1'b1, 1'b0);

    stim.delete();
    for (int i = 0; i < 260; i++) stim.push_back(W'(i));
    drain(0, 1'b0, 1'b0);

    // Abort during WAIT of the second pop
    stim = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    elems = stim;
    gen++;
    b  = got.size();
    p0 = pop_cyc.size();
    d0 = dones;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 200 && pop_cyc.size() - p0 < 2; k++) tick(1);
    check("abort_reached_pop2", pop_cyc.size() - p0, 2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_m_valid", 32'(bus.m_valid), 0);
    tick(20);
    check("abort_no_done", dones - d0, 0);
    check("abort_count", 32'(count), 1);
    check("abort_emitted", got.size() - b, 1);
    check("abort_pops", pop_cyc.size() - p0, 2);

    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    tick(5);
    check("start_abort_idle", 32'(busy), 0);
    check("start_abort_pops", pop_cyc.size() - p0, 2);

    // Reset in the middle of a drain
    stim = '{16'd20, 16'd30, 16'd40};
    elems = stim;
    gen++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    v = bus.m_data;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_count", 32'(count), 0);
    check("rst_mid_m_valid", 32'(bus.m_valid), 0);
    check("rst_mid_m_data", 32'(v), 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
